// File: rtl/alarm_trigger_if.sv
// Alarm trigger bus: armed/setting/buttons, BCD time pairs in,
// ring/snooze status out.
interface alarm_trigger_if;
    logic       enable;
    logic       setting;
    logic       tick_1hz;
    logic       dismiss;
    logic       snooze;
    logic [3:0] cur_min10;
    logic [3:0] cur_min01;
    logic [3:0] cur_sec10;
    logic [3:0] cur_sec01;
    logic [3:0] alarm_min10;
    logic [3:0] alarm_min01;
    logic [3:0] alarm_sec10;
    logic [3:0] alarm_sec01;
    logic       ringing;
    logic       buzzer;
    logic       snoozing;
    logic [1:0] snooze_count;
    logic [7:0] remain_sec;

    modport master (
        output enable, setting, tick_1hz, dismiss, snooze,
        output cur_min10, cur_min01, cur_sec10, cur_sec01,
        output alarm_min10, alarm_min01, alarm_sec10, alarm_sec01,
        input  ringing, buzzer, snoozing, snooze_count, remain_sec
    );

    modport slave (
        input  enable, setting, tick_1hz, dismiss, snooze,
        input  cur_min10, cur_min01, cur_sec10, cur_sec01,
        input  alarm_min10, alarm_min01, alarm_sec10, alarm_sec01,
        output ringing, buzzer, snoozing, snooze_count, remain_sec
    );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm trigger FSM: ring on rising time match, timeout, dismiss.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_trigger #(
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 60,
    parameter int MAX_SNOOZE = 3,
    parameter int BEEP_HALF  = 4
) (
    input  logic          MCLK,
    input  logic          RESET,
    alarm_trigger_if.slave bus
);

    localparam int BW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RINGING,
        SNOOZE
    } state_t;

    state_t        state;
    logic          match;
    logic          match_prev;
    logic          trig;
    logic [BW-1:0] beep_cnt;
    logic          ring_q;
    logic          buzz_q;
    logic          snz_q;
    logic [1:0]    cnt_q;
    logic [7:0]    remain_q;

    assign match = ({bus.cur_min10, bus.cur_min01,
                     bus.cur_sec10, bus.cur_sec01} ==
                    {bus.alarm_min10, bus.alarm_min01,
                     bus.alarm_sec10, bus.alarm_sec01});
    assign trig  = match & ~match_prev;

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            match_prev <= 1'b0;
            beep_cnt   <= '0;
            ring_q     <= 1'b0;
            buzz_q     <= 1'b0;
            snz_q      <= 1'b0;
            cnt_q      <= 2'd0;
            remain_q   <= 8'd0;
        end else begin
            match_prev <= match;
            if (!bus.enable) begin
                state    <= IDLE;
                beep_cnt <= '0;
                ring_q   <= 1'b0;
                buzz_q   <= 1'b0;
                snz_q    <= 1'b0;
                cnt_q    <= 2'd0;
                remain_q <= 8'd0;
            end else begin
                unique case (state)
                    IDLE: state <= ARMED;
                    ARMED: begin
                        if (trig && !bus.setting) begin
                            state    <= RINGING;
                            ring_q   <= 1'b1;
                            buzz_q   <= 1'b1;
                            beep_cnt <= '0;
                            remain_q <= RING_SEC[7:0];
                        end
                    end
                    RINGING: begin
                        if (beep_cnt == BEEP_LAST) begin
                            beep_cnt <= '0;
                            buzz_q   <= ~buzz_q;
                        end else begin
                            beep_cnt <= beep_cnt + 1'b1;
                        end
                        // Buttons outrank ticks; setting outranks buttons.
                        if (bus.setting || bus.dismiss) begin
                            state    <= ARMED;
                            beep_cnt <= '0;
                            ring_q   <= 1'b0;
                            buzz_q   <= 1'b0;
                            cnt_q    <= 2'd0;
                            remain_q <= 8'd0;
`ifdef ALARM_SNOOZE_EN
                        end else if (bus.snooze) begin
                            beep_cnt <= '0;
                            ring_q   <= 1'b0;
                            buzz_q   <= 1'b0;
                            if (cnt_q < MAX_SNOOZE[1:0]) begin
                                state    <= SNOOZE;
                                snz_q    <= 1'b1;
                                cnt_q    <= cnt_q + 2'd1;
                                remain_q <= SNOOZE_SEC[7:0];
                            end else begin
                                state    <= ARMED;
                                cnt_q    <= 2'd0;
                                remain_q <= 8'd0;
                            end
`endif
                        end else if (bus.tick_1hz) begin
                            if (remain_q == 8'd1) begin
                                state    <= ARMED;
                                beep_cnt <= '0;
                                ring_q   <= 1'b0;
                                buzz_q   <= 1'b0;
                                cnt_q    <= 2'd0;
                                remain_q <= 8'd0;
                            end else begin
                                remain_q <= remain_q - 8'd1;
                            end
                        end
                    end
                    SNOOZE: begin
                        if (bus.setting || bus.dismiss) begin
                            state    <= ARMED;
                            snz_q    <= 1'b0;
                            cnt_q    <= 2'd0;
                            remain_q <= 8'd0;
                        end else if (bus.tick_1hz) begin
                            if (remain_q == 8'd1) begin
                                state    <= RINGING;
                                snz_q    <= 1'b0;
                                ring_q   <= 1'b1;
                                buzz_q   <= 1'b1;
                                beep_cnt <= '0;
                                remain_q <= RING_SEC[7:0];
                            end else begin
                                remain_q <= remain_q - 8'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifndef ALARM_SNOOZE_EN
    logic unused_snz;
    assign unused_snz = ^{bus.snooze, SNOOZE_SEC[7:0], MAX_SNOOZE[1:0]};
`endif

    assign bus.ringing      = ring_q;
    assign bus.buzzer       = buzz_q;
    assign bus.snoozing     = snz_q;
    assign bus.snooze_count = cnt_q;
    assign bus.remain_sec   = remain_q;

endmodule
